trap_ctrl: RTL

Trap sequencer for the machine-mode CSR file: it detects synchronous exceptions, `mret`, and masked interrupt requests at the instruction boundary, then drains the pipeline through a flush handshake. It drives the CSR file's trap-entry and return strobes with stable `mepc`/`mcause` values and redirects the PC to the trap vector or to `mepc`. It sits between the decode/execute stage, the CSR file and the PC logic.

---
 rtl/trap_ctrl_if.sv | 45 ++++
 rtl/trap_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/trap_ctrl_if.sv
// Boundary bundle between decode/execute, the CSR file and PC logic and the trap sequencer.
// master drives the decode/CSR-side inputs; slave is the sequencer view.
interface trap_ctrl_if;
    localparam int unsigned XLEN = 32;

    logic            instr_valid;
    logic [XLEN-1:0] pc_in;
    logic            ecall;
    logic            mret;
    logic            illegal;
    logic            irq_sw;
    logic            irq_timer;
    logic            irq_ext;
    logic            mstatus_mie;
    logic [XLEN-1:0] mie_in;
    logic [XLEN-1:0] mtvec_in;
    logic [XLEN-1:0] mepc_in;
    logic            flush_ack;

    logic            kill;
    logic            stall;
    logic            flush_req;
    logic            trap_take;
    logic            trap_ret;
    logic [XLEN-1:0] mepc_out;
    logic [XLEN-1:0] mcause_out;
    logic [XLEN-1:0] mip_out;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            drain_timeout;

    modport master (
        output instr_valid, pc_in, ecall, mret, illegal,
        output irq_sw, irq_timer, irq_ext, mstatus_mie, mie_in, mtvec_in, mepc_in, flush_ack,
        input  kill, stall, flush_req, trap_take, trap_ret, mepc_out, mcause_out, mip_out,
        input  redirect_valid, redirect_pc, drain_timeout
    );

    modport slave (
        input  instr_valid, pc_in, ecall, mret, illegal,
        input  irq_sw, irq_timer, irq_ext, mstatus_mie, mie_in, mtvec_in, mepc_in, flush_ack,
        output kill, stall, flush_req, trap_take, trap_ret, mepc_out, mcause_out, mip_out,
        output redirect_valid, redirect_pc, drain_timeout
    );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: detect, drain, then strobe trap entry or mret to the CSR file.
// Optional TRAP_VECTORED_EN: interrupts vector to base + 4*cause when mtvec mode is 01.
module trap_ctrl (
    input  logic       clk,
    input  logic       reset_x,
    trap_ctrl_if.slave bus
);
    localparam int unsigned XLEN      = 32;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned DRAIN_MAX = 15;

    localparam logic [XLEN-1:0] CAUSE_MSI     = 32'h8000_0003;
    localparam logic [XLEN-1:0] CAUSE_MTI     = 32'h8000_0007;
    localparam logic [XLEN-1:0] CAUSE_MEI     = 32'h8000_000B;
    localparam logic [XLEN-1:0] CAUSE_ILLEGAL = 32'd2;
    localparam logic [XLEN-1:0] CAUSE_ECALL   = 32'd11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        ENTER  = 2'd2,
        RETURN = 2'd3
    } state_e;

    state_e          state_q;
    logic [CNT_W-1:0] cnt_q;
    logic            is_ret_q;
    logic            stall_q;
    logic            flush_req_q;
    logic            trap_take_q;
    logic            trap_ret_q;
    logic            redirect_valid_q;
    logic [XLEN-1:0] redirect_pc_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mip_q;
    logic            drain_timeout_q;

    logic [XLEN-1:0] mip_d;
    logic [XLEN-1:0] cause_d;
    logic [XLEN-1:0] vec_base;
    logic [XLEN-1:0] vec_target;
    logic            int_p;
    logic            event_c;
    logic            is_ret_d;
    logic            timeout_c;

    // Event detection and cause priority at the instruction boundary.
    always_comb begin
        mip_d      = '0;
        mip_d[3]   = bus.irq_sw;
        mip_d[7]   = bus.irq_timer;
        mip_d[11]  = bus.irq_ext;
        int_p      = bus.mstatus_mie & (|(mip_q & bus.mie_in));
        event_c    = (state_q == IDLE) & bus.instr_valid &
                     (int_p | bus.illegal | bus.ecall | bus.mret);
        is_ret_d   = ~int_p & ~bus.illegal & ~bus.ecall;
        cause_d    = mcause_q;
        if (int_p) begin
            if (mip_q[11] & bus.mie_in[11])     cause_d = CAUSE_MEI;
            else if (mip_q[3] & bus.mie_in[3])  cause_d = CAUSE_MSI;
            else                                cause_d = CAUSE_MTI;
        end else if (bus.illegal) begin
            cause_d = CAUSE_ILLEGAL;
        end else if (bus.ecall) begin
            cause_d = CAUSE_ECALL;
        end
        timeout_c  = (cnt_q == CNT_W'(DRAIN_MAX - 1));
        vec_base   = {bus.mtvec_in[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
        if ((bus.mtvec_in[1:0] == 2'b01) && mcause_q[XLEN-1])
            vec_target = vec_base + XLEN'({mcause_q[3:0], 2'b00});
        else
            vec_target = vec_base;
`else
        vec_target = vec_base;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_x) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            is_ret_q         <= 1'b0;
            stall_q          <= 1'b0;
            flush_req_q      <= 1'b0;
            trap_take_q      <= 1'b0;
            trap_ret_q       <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            mepc_q           <= '0;
            mcause_q         <= '0;
            mip_q            <= '0;
            drain_timeout_q  <= 1'b0;
        end else begin
            mip_q            <= mip_d;
            trap_take_q      <= 1'b0;
            trap_ret_q       <= 1'b0;
            redirect_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (event_c) begin
                        state_q     <= DRAIN;
                        cnt_q       <= '0;
                        is_ret_q    <= is_ret_d;
                        mepc_q      <= bus.pc_in;
                        mcause_q    <= cause_d;
                        stall_q     <= 1'b1;
                        flush_req_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (bus.flush_ack || timeout_c) begin
                        // ack wins over a coincident timeout, so the flag marks real stalls only
                        if (!bus.flush_ack) drain_timeout_q <= 1'b1;
                        flush_req_q      <= 1'b0;
                        redirect_valid_q <= 1'b1;
                        if (is_ret_q) begin
                            state_q       <= RETURN;
                            trap_ret_q    <= 1'b1;
                            redirect_pc_q <= bus.mepc_in;
                        end else begin
                            state_q       <= ENTER;
                            trap_take_q   <= 1'b1;
                            redirect_pc_q <= vec_target;
                        end
                    end
                end
                ENTER, RETURN: begin
                    state_q <= IDLE;
                    stall_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.kill           = event_c;
    assign bus.stall          = stall_q;
    assign bus.flush_req      = flush_req_q;
    assign bus.trap_take      = trap_take_q;
    assign bus.trap_ret       = trap_ret_q;
    assign bus.mepc_out       = mepc_q;
    assign bus.mcause_out     = mcause_q;
    assign bus.mip_out        = mip_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.drain_timeout  = drain_timeout_q;
endmodule
